// File: rtl/imem_responder.sv
// imem_responder: memory end of the instruction-fetch interface.
//   Accepts one word fetch at a time over valid/ready, returns the word after
//   LATENCY wait states (response held until rsp_ready), and flags misaligned or
//   out-of-range addresses with rsp_err and an addi x0,x0,0 payload.
//   A byte-serial load port writes little-endian program words into the same
//   storage while fetches are held off (req_ready low whenever load_en is high).
// Ports:
//   clk, reset            : clock, asynchronous active-high reset
//   req_valid/req_ready   : fetch request handshake, req_addr is a byte address
//   rsp_valid/rsp_ready   : response handshake, rsp_data/rsp_err qualified by rsp_valid
//   load_en, load_valid   : program-load mode request and per-byte strobe
//   load_byte             : program byte stream, least significant byte first
//   load_words            : words written since LOAD was entered (saturating)
//   load_overflow         : sticky, write pointer wrapped during this load
module imem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int LATENCY     = 2
) (
   input  logic                         clk,
   input  logic                         reset,
   input  logic                         req_valid,
   input  logic [31:0]                  req_addr,
   output logic                         req_ready,
   output logic                         rsp_valid,
   input  logic                         rsp_ready,
   output logic [31:0]                  rsp_data,
   output logic                         rsp_err,
   input  logic                         load_en,
   input  logic                         load_valid,
   input  logic [7:0]                   load_byte,
   output logic [$clog2(DEPTH_WORDS):0] load_words,
   output logic                         load_overflow
);

   localparam int          AW        = $clog2(DEPTH_WORDS);
   localparam logic [31:0] NOP_INSN  = 32'h0000_0013;
   localparam logic [2:0]  LAT_M1    = (LATENCY > 0) ? 3'(LATENCY - 1) : 3'd0;
   localparam logic [AW:0] WORDS_MAX = (AW + 1)'(DEPTH_WORDS);

   typedef enum logic [1:0] {IDLE, WAIT, RESP, LOAD} state_t;

   // Instruction storage; deliberately not reset so a loaded image survives reset.
   logic [31:0] mem [DEPTH_WORDS];

   state_t        state_q, state_d;
   logic [2:0]    cnt_q, cnt_d;
   logic [AW-1:0] addr_q, addr_d;
   logic          err_q, err_d;
   logic          rsp_valid_q, rsp_valid_d;
   logic [31:0]   rsp_data_q, rsp_data_d;
   logic          rsp_err_q, rsp_err_d;
   logic [AW-1:0] wptr_q, wptr_d;
   logic [1:0]    idx_q, idx_d;
   logic [23:0]   asm_q, asm_d;        // bytes 0..2 of the word being assembled
   logic [AW:0]   words_q, words_d;
   logic          ovf_q, ovf_d;
   logic          mem_we;
   logic          req_err;

   // Aligned and inside the array: low two bits zero and no address bits above the index.
   assign req_err = (req_addr[1:0] != 2'b00) || (req_addr[31:AW+2] != '0);

   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      addr_d      = addr_q;
      err_d       = err_q;
      rsp_valid_d = rsp_valid_q;
      rsp_data_d  = rsp_data_q;
      rsp_err_d   = rsp_err_q;
      wptr_d      = wptr_q;
      idx_d       = idx_q;
      asm_d       = asm_q;
      words_d     = words_q;
      ovf_d       = ovf_q;
      mem_we      = 1'b0;

      case (state_q)
         IDLE: begin
            // Load mode wins over a pending fetch.
            if (load_en) begin
               state_d = LOAD;
               wptr_d  = '0;
               idx_d   = '0;
               asm_d   = '0;
               words_d = '0;
               ovf_d   = 1'b0;
            end else if (req_valid) begin
               addr_d = req_addr[AW+1:2];
               err_d  = req_err;
               if (LATENCY == 0) begin
                  // Zero wait states: read straight from the request address.
                  state_d     = RESP;
                  rsp_valid_d = 1'b1;
                  rsp_err_d   = req_err;
                  rsp_data_d  = req_err ? NOP_INSN : mem[req_addr[AW+1:2]];
               end else begin
                  state_d = WAIT;
                  cnt_d   = LAT_M1;
               end
            end
         end

         WAIT: begin
            if (cnt_q == 3'd0) begin
               // Data is registered here so it is already stable in the first RESP cycle.
               state_d     = RESP;
               rsp_valid_d = 1'b1;
               rsp_err_d   = err_q;
               rsp_data_d  = err_q ? NOP_INSN : mem[addr_q];
            end else begin
               cnt_d = cnt_q - 1'b1;
            end
         end

         RESP: begin
            if (rsp_ready) begin
               state_d     = IDLE;
               rsp_valid_d = 1'b0;
            end
         end

         LOAD: begin
            if (!load_en) begin
               // Any partially assembled word is dropped.
               state_d = IDLE;
               idx_d   = '0;
               asm_d   = '0;
            end else if (load_valid) begin
               if (idx_q == 2'd3) begin
                  mem_we = 1'b1;
                  idx_d  = '0;
                  asm_d  = '0;
                  wptr_d = wptr_q + 1'b1;
                  if (&wptr_q) begin
                     ovf_d = 1'b1;
                  end
                  if (words_q != WORDS_MAX) begin
                     words_d = words_q + 1'b1;
                  end
               end else begin
                  idx_d              = idx_q + 1'b1;
                  asm_d[8*idx_q +: 8] = load_byte;
               end
            end
         end

         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         addr_q      <= '0;
         err_q       <= 1'b0;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
         rsp_err_q   <= 1'b0;
         wptr_q      <= '0;
         idx_q       <= '0;
         asm_q       <= '0;
         words_q     <= '0;
         ovf_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         addr_q      <= addr_d;
         err_q       <= err_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
         rsp_err_q   <= rsp_err_d;
         wptr_q      <= wptr_d;
         idx_q       <= idx_d;
         asm_q       <= asm_d;
         words_q     <= words_d;
         ovf_q       <= ovf_d;
      end
   end

   // The 4th byte goes straight into the top lane on the edge that samples it.
   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem[wptr_q] <= {load_byte, asm_q};
      end
   end

   assign req_ready     = (state_q == IDLE) && !load_en;
   assign rsp_valid     = rsp_valid_q;
   assign rsp_data      = rsp_data_q;
   assign rsp_err       = rsp_err_q;
   assign load_words    = words_q;
   assign load_overflow = ovf_q;

endmodule

// File: tb/tb_imem_responder.sv
module tb_imem_responder;

   localparam int D   = 16;
   localparam int LAT = 2;
   localparam int LW  = $clog2(D) + 1;

   logic          clk = 1'b0;
   logic          reset;
   logic          req_valid = 1'b0;
   logic [31:0]   req_addr = '0;
   logic          req_ready;
   logic          rsp_valid;
   logic          rsp_ready = 1'b0;
   logic [31:0]   rsp_data;
   logic          rsp_err;
   logic          load_en = 1'b0;
   logic          load_valid = 1'b0;
   logic [7:0]    load_byte = '0;
   logic [LW-1:0] load_words;
   logic          load_overflow;

   imem_responder #(.DEPTH_WORDS(D), .LATENCY(LAT)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data), .rsp_err(rsp_err),
      .load_en(load_en), .load_valid(load_valid), .load_byte(load_byte),
      .load_words(load_words), .load_overflow(load_overflow)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   task automatic timeout(input string name);
      checks++;
      failures++;
      $display("FAIL %s: timed out waiting at t=%0t", name, $time);
   endtask

   // ---------------- behavioural reference model ----------------
   logic [31:0] mem_m [D];
   bit          known [D];
   bit          m_busy, m_valid, m_err, m_chk, m_loading, m_ovf;
   int          m_left, m_nb, m_wptr, m_words;
   logic [31:0] m_data, m_asm;

   always @(posedge clk or posedge reset) begin
      if (reset) begin
         m_busy = 0; m_valid = 0; m_loading = 0;
         m_nb = 0; m_asm = 0; m_wptr = 0; m_words = 0; m_ovf = 0;
      end else if (m_loading) begin
         if (!load_en) begin
            m_loading = 0;
         end else if (load_valid) begin
            m_asm = m_asm | (32'(load_byte) << (8 * m_nb));
            m_nb++;
            if (m_nb == 4) begin
               mem_m[m_wptr] = m_asm;
               known[m_wptr] = 1;
               m_wptr = (m_wptr + 1) % D;
               if (m_wptr == 0) m_ovf = 1;
               if (m_words < D) m_words++;
               m_nb = 0;
               m_asm = 0;
            end
         end
      end else if (m_busy) begin
         if (m_valid) begin
            if (rsp_ready) begin m_busy = 0; m_valid = 0; end
         end else begin
            m_left--;
            if (m_left == 0) m_valid = 1;
         end
      end else if (load_en) begin
         m_loading = 1; m_nb = 0; m_asm = 0; m_wptr = 0; m_words = 0; m_ovf = 0;
      end else if (req_valid) begin
         m_busy = 1;
         m_err  = (req_addr % 4 != 0) || (req_addr / 4 >= D);
         if (m_err) begin
            m_data = 32'h0000_0013;
            m_chk  = 1;
         end else begin
            m_data = mem_m[req_addr / 4];
            m_chk  = known[req_addr / 4];
         end
         if (LAT == 0) m_valid = 1;
         else m_left = LAT;
      end
   end

   // Single compare process, sampled on the falling edge.
   always @(negedge clk) begin
      if (reset === 1'b0) begin
         chk("req_ready", 32'(req_ready), 32'(!m_busy && !m_loading && !load_en));
         chk("rsp_valid", 32'(rsp_valid), 32'(m_valid));
         if (m_valid) begin
            chk("rsp_err", 32'(rsp_err), 32'(m_err));
            if (m_chk) chk("rsp_data", rsp_data, m_data);
         end
         chk("load_words", 32'(load_words), 32'(m_words));
         chk("load_overflow", 32'(load_overflow), 32'(m_ovf));
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_fetch(input logic [31:0] a, input int hold, input bit raise_load,
                           output logic [31:0] d, output logic e, output int lat);
      int n;
      d = 'x; e = 'x; lat = -1;
      req_valid = 1; req_addr = a;
      n = 0;
      while (!req_ready && n < 50) begin tick(); n++; end
      if (!req_ready) begin timeout("accept"); req_valid = 0; return; end
      tick();
      req_valid = 0; req_addr = $urandom;
      if (raise_load) load_en = 1;
      n = 0;
      while (!rsp_valid && n < 50) begin tick(); n++; end
      if (!rsp_valid) begin timeout("rsp_valid"); return; end
      lat = n;
      repeat (hold) tick();
      d = rsp_data; e = rsp_err;
      rsp_ready = 1;
      tick();
      rsp_ready = 0;
   endtask

   task automatic load_bytes(input logic [7:0] b[$], input bit gaps);
      load_en = 1;
      tick();
      foreach (b[i]) begin
         if (gaps) repeat ($urandom_range(0, 2)) begin load_valid = 0; tick(); end
         load_valid = 1; load_byte = b[i];
         tick();
      end
      load_valid = 0;
   endtask

   task automatic load_end();
      load_en = 0;
      tick();
   endtask

   // ---------------- test sequence ----------------
   logic [31:0] d, w[17], nw;
   logic        e;
   int          lat;
   logic [7:0]  q[$];

   initial begin
      reset = 0;
      #1 reset = 1;
      #1;
      chk("reset rsp_valid", 32'(rsp_valid), 0);
      chk("reset rsp_data", rsp_data, 0);
      chk("reset rsp_err", 32'(rsp_err), 0);
      chk("reset load_words", 32'(load_words), 0);
      chk("reset load_overflow", 32'(load_overflow), 0);
      chk("reset req_ready", 32'(req_ready), 1);
      load_en = 1;
      #1 chk("reset req_ready follows load_en", 32'(req_ready), 0);
      load_en = 0;
      #9 reset = 0;
      tick();

      // Two-word program image.
      q = '{8'h13, 8'h05, 8'h10, 8'h00, 8'h93, 8'h05, 8'hF0, 8'hFF};
      load_bytes(q, 1);
      load_end();
      chk("image load_words", 32'(load_words), 2);
      do_fetch(0, 0, 0, d, e, lat);
      chk("fetch0 data", d, 32'h00100513);
      chk("fetch0 err", 32'(e), 0);
      chk("fetch0 latency", lat, LAT);
      do_fetch(4, 5, 0, d, e, lat);
      chk("fetch4 data", d, 32'hFFF00593);
      chk("fetch4 err", 32'(e), 0);

      // Error fetches.
      do_fetch(32'h6, 0, 0, d, e, lat);
      chk("misaligned err", 32'(e), 1);
      chk("misaligned data", d, 32'h00000013);
      do_fetch(32'(4 * D), 1, 0, d, e, lat);
      chk("out of range err", 32'(e), 1);
      chk("out of range data", d, 32'h00000013);
      chk("error latency", lat, LAT);

      // Overflow: 17 words into a 16-word array.
      q = {};
      for (int i = 0; i < 17; i++) begin
         w[i] = $urandom;
         for (int k = 0; k < 4; k++) q.push_back(w[i][8*k +: 8]);
      end
      load_bytes(q, 0);
      load_end();
      chk("ovf load_words", 32'(load_words), 16);
      chk("ovf flag", 32'(load_overflow), 1);
      do_fetch(0, 0, 0, d, e, lat);
      chk("ovf word0", d, w[16]);
      do_fetch(4, 0, 0, d, e, lat);
      chk("ovf word1", d, w[1]);

      // Six bytes: one full word plus a discarded partial.
      nw = $urandom;
      q = {};
      for (int k = 0; k < 4; k++) q.push_back(nw[8*k +: 8]);
      q.push_back(8'hAA); q.push_back(8'h55);
      load_bytes(q, 1);
      load_end();
      chk("partial load_words", 32'(load_words), 1);
      chk("partial ovf cleared", 32'(load_overflow), 0);
      do_fetch(4, 0, 0, d, e, lat);
      chk("partial word1 unchanged", d, w[1]);
      do_fetch(0, 0, 0, d, e, lat);
      chk("partial word0", d, nw);

      // load_en raised while waiting; requests during LOAD are refused.
      do_fetch(4, 1, 1, d, e, lat);
      chk("load during wait data", d, w[1]);
      req_valid = 1; req_addr = 0;
      nw = $urandom;
      q = {};
      for (int k = 0; k < 4; k++) q.push_back(nw[8*k +: 8]);
      load_bytes(q, 1);
      req_valid = 0;
      load_end();
      do_fetch(0, 0, 0, d, e, lat);
      chk("after wait-load word0", d, nw);

      // Reset while a response is pending.
      req_valid = 1; req_addr = 4;
      tick();
      req_valid = 0;
      for (int n = 0; n < 20 && !rsp_valid; n++) tick();
      chk("pre-reset rsp_valid", 32'(rsp_valid), 1);
      #2 reset = 1;
      #1;
      chk("async reset rsp_valid", 32'(rsp_valid), 0);
      chk("async reset req_ready", 32'(req_ready), 1);
      #3 reset = 0;
      tick();
      do_fetch(4, 0, 0, d, e, lat);
      chk("word1 after reset", d, w[1]);

      // Reset mid-load: completed word persists, partial is lost.
      nw = $urandom;
      q = {};
      for (int k = 0; k < 4; k++) q.push_back(nw[8*k +: 8]);
      q.push_back(8'h11); q.push_back(8'h22);
      load_bytes(q, 0);
      load_en = 0;
      #2 reset = 1;
      #3 reset = 0;
      tick();
      do_fetch(0, 0, 0, d, e, lat);
      chk("mid-load reset word0", d, nw);
      do_fetch(4, 0, 0, d, e, lat);
      chk("mid-load reset word1", d, w[1]);

      // Randomised traffic against the model.
      for (int it = 0; it < 300; it++) begin
         if ($urandom_range(0, 9) == 0) begin
            q = {};
            repeat ($urandom_range(0, 40)) q.push_back(8'($urandom));
            load_bytes(q, 1);
            load_end();
         end else begin
            logic [31:0] a;
            if ($urandom_range(0, 7) == 0) a = $urandom;
            else if ($urandom_range(0, 3) == 0) a = $urandom_range(0, 4 * D + 7);
            else a = 32'(4 * $urandom_range(0, D - 1));
            do_fetch(a, $urandom_range(0, 3), 0, d, e, lat);
         end
         repeat ($urandom_range(0, 2)) tick();
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish, got running expected finished");
      failures++;
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $fatal(1, "watchdog");
   end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder: the memory end of the fetch interface on which the RV32I core is the initiator. It accepts word-fetch requests over a valid/ready handshake, returns the 32-bit instruction after a configurable number of wait states, and flags misaligned or out-of-range fetches. A byte-serial load port (bootloader side) writes program images into the same storage while fetches are held off.

## Interface
- DEPTH_WORDS, 256: number of 32-bit instruction words; power of two, 16..4096.
- LATENCY, 2: wait states between request acceptance and response; 0..7.
- clk  in  1  clock; every register samples on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  1  fetch request present.
- req_addr  in  32  byte address of the instruction.
- req_ready  out  1  responder can accept a request; equals (state==IDLE && !load_en).
- rsp_valid  out  1  response present; held until rsp_ready.
- rsp_ready  in  1  initiator takes the response.
- rsp_data  out  32  instruction word, or 32'h0000_0013 (addi x0,x0,0) on error.
- rsp_err  out  1  fetch was misaligned or out of range; qualified by rsp_valid.
- load_en  in  1  program-load mode request.
- load_valid  in  1  load_byte is valid this cycle; ignored unless in LOAD.
- load_byte  in  8  program byte, little-endian stream.
- load_words  out  $clog2(DEPTH_WORDS)+1  words written since LOAD was entered.
- load_overflow  out  1  sticky: write pointer wrapped during the current load.

## Operation
- States: IDLE, WAIT, RESP, LOAD.
- IDLE: req_valid && req_ready accepts; address latched, error evaluated: err = (req_addr[1:0]!=0) || (req_addr[31:2] >= DEPTH_WORDS). Next state is WAIT if LATENCY>0 (counter loaded with LATENCY-1), else RESP.
- WAIT: counter decrements each cycle; at 0, goes to RESP. Memory read is issued so rsp_data is stable on entry to RESP.
- RESP: rsp_valid=1, rsp_data/rsp_err stable. On rsp_ready goes to IDLE; otherwise holds indefinitely.
- Error fetch: same latency as a normal fetch; rsp_err=1, rsp_data=32'h0000_0013; memory is not read.
- IDLE with load_en=1 (priority over req_valid; req_ready is 0): goes to LOAD, clears write pointer, byte index, load_words, load_overflow.
- load_en asserted in WAIT/RESP: in-flight fetch completes normally; LOAD is entered from IDLE afterward.
- LOAD: each load_valid byte is placed in assembly lane [8*idx+:8], idx 0..3. On the 4th byte the assembled word is written at wptr, wptr increments, load_words increments. wptr wraps DEPTH_WORDS-1 -> 0 and sets load_overflow; load_words saturates at DEPTH_WORDS.
- load_en deasserted in LOAD: goes to IDLE next cycle. A partial word (1-3 bytes) is discarded, no write occurs. load_words and load_overflow hold their values until the next LOAD entry.
- Memory contents are not cleared by reset. Words written in LOAD are fetchable from the first IDLE cycle after LOAD.

## Timing
- Reset values: state IDLE, rsp_valid 0, rsp_data 0, rsp_err 0, load_words 0, load_overflow 0, wptr 0, idx 0, counter 0. req_ready follows load_en during reset release.
- Acceptance edge E0. rsp_valid is first high in the cycle after edge E(LATENCY). LATENCY=0 gives rsp_valid in the cycle immediately after acceptance.
- No pipelining: next req_ready is the cycle after the rsp handshake edge, giving at most one fetch per LATENCY+2 cycles with rsp_ready tied high.
- Reset mid-fetch or mid-load: immediate abort to the reset values. A partially assembled word is lost; completed word writes persist.
- Load byte rate: one byte per cycle maximum; the word write occurs on the edge that samples the 4th byte.

## Test plan
- Load bytes 13,05,10,00,93,05,F0,FF, then drop load_en -> load_words=2. Fetch addr 0 -> rsp_data 32'h00100513. Fetch addr 4 -> 32'hFFF00593, rsp_err=0.
- LATENCY=2, request accepted at edge E0 -> rsp_valid rises after E2. With rsp_ready held low 5 cycles, rsp_data stays constant and req_ready stays 0.
- Fetch addr 32'h0000_0006 -> rsp_err=1, rsp_data 32'h00000013. Fetch addr 4*DEPTH_WORDS -> same error response.
- DEPTH_WORDS=16: load 17 words -> load_overflow=1, load_words=16, word 0 holds the 17th word. Load 6 bytes, then drop load_en -> load_words=1, word 1 unchanged.
- load_en raised during WAIT -> fetch response completes with correct data, then LOAD is entered. req_valid during LOAD -> never accepted.
- Assert reset in RESP with rsp_valid=1 -> rsp_valid=0 and req_ready=1 asynchronously. Previously loaded words are still readable after reset.
